// File: rtl/cla_adder_8.sv
// cla_adder_8: 8-bit two-level carry-lookahead adder with a registered output.
// Two 4-bit CLA groups form their internal carries directly from the per-bit
// generate/propagate terms. A second-level unit combines the group G/P terms
// to produce the carry into bit 4 and the final carry out. The 9-bit result
// is captured on every rising clock edge, so the latency is one cycle.

module cla_adder_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    // Internal carries of a 4-bit group. Bit 0 carries the group carry-in,
    // and each higher carry is a flat sum of products (no ripple chain).
    function automatic logic [3:0] cla4_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       ci
    );
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Group generate: the group produces a carry regardless of its carry-in.
    function automatic logic cla4_group_gen(
        input logic [3:0] g,
        input logic [3:0] p
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Group propagate: the group passes its carry-in straight through.
    function automatic logic cla4_group_prop(
        input logic [3:0] p
    );
        return p[3] & p[2] & p[1] & p[0];
    endfunction

    logic [7:0] g_s;
    logic [7:0] p_s;
    logic [7:0] c_s;
    logic       grp_g0_s;
    logic       grp_p0_s;
    logic       grp_g1_s;
    logic       grp_p1_s;
    logic       c4_s;
    logic       cout_comb_s;
    logic [7:0] sum_s;

    // Per-bit generate/propagate terms and the group G/P terms.
    always_comb begin
        g_s      = a & b;
        p_s      = a ^ b;
        grp_g0_s = cla4_group_gen(g_s[3:0], p_s[3:0]);
        grp_p0_s = cla4_group_prop(p_s[3:0]);
        grp_g1_s = cla4_group_gen(g_s[7:4], p_s[7:4]);
        grp_p1_s = cla4_group_prop(p_s[7:4]);
    end

    // Second-level lookahead: the carry into the upper group and the final
    // carry out both come from group terms and cin alone.
    always_comb begin
        c4_s        = grp_g0_s | (grp_p0_s & cin);
        cout_comb_s = grp_g1_s | (grp_p1_s & grp_g0_s)
                    | (grp_p1_s & grp_p0_s & cin);
    end

    // Carries for each bit from the two groups, then the sum bits.
    always_comb begin
        c_s[3:0] = cla4_carries(g_s[3:0], p_s[3:0], cin);
        c_s[7:4] = cla4_carries(g_s[7:4], p_s[7:4], c4_s);
        sum_s    = p_s ^ c_s;
    end

    // Output register: new result every edge. Reset clears the register
    // immediately and discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= 8'h00;
            cout <= 1'b0;
        end else begin
            s    <= sum_s;
            cout <= cout_comb_s;
        end
    end

endmodule

// File: tb/tb_cla_adder_8.sv
// tb_cla_adder_8: table-driven directed vectors, plus hand-written sequences
// for the reset and between-edge cases, and a random sweep against a + b + cin.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge after the capturing rising edge.

module tb_cla_adder_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_s;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[10];

    cla_adder_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {cout,s}=%h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [8:0] exp_r;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        vecs[2] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};

        // Reset held with nonzero inputs: outputs must stay clear.
        rst_n = 1'b0;
        a     = 8'h5C;
        b     = 8'hA7;
        cin   = 1'b1;
        #1;
        check("reset_before_edge", {cout, s}, 9'h000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_with_clock", {cout, s}, 9'h000);

        // Release reset and apply the directed table back to back.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a   = vecs[i].a;
            b   = vecs[i].b;
            cin = vecs[i].cin;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_%h+%h+%0d", i, vecs[i].a, vecs[i].b, vecs[i].cin),
                  {cout, s}, {vecs[i].exp_cout, vecs[i].exp_s});
        end

        // The output must hold while inputs change between edges.
        a   = 8'h12;
        b   = 8'h34;
        cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold_load", {cout, s}, 9'h046);
        a   = 8'hFF;
        b   = 8'h01;
        cin = 1'b1;
        #2;
        check("hold_between_edges", {cout, s}, 9'h046);

        // Asynchronous reset in the middle of the stream.
        @(negedge clk);
        check("pre_reset_load", {cout, s}, 9'h101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_no_edge", {cout, s}, 9'h000);
        @(negedge clk);
        check("async_reset_held", {cout, s}, 9'h000);

        // The first edge after release loads the inputs present at that edge.
        rst_n = 1'b1;
        a     = 8'h05;
        b     = 8'h03;
        cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_edge_after_reset", {cout, s}, 9'h008);

        // Random sweep against the arithmetic reference.
        for (int i = 0; i < 400; i++) begin
            a     = 8'($urandom_range(255, 0));
            b     = 8'($urandom_range(255, 0));
            cin   = 1'($urandom_range(1, 0));
            exp_r = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rand%0d_%h+%h+%0d", i, a, b, cin), {cout, s}, exp_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_adder_8.md
CLA_ADDER_8 -- requirements
Module: cla_adder_8

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for the output register.
REQ-004 rst_n  input  1  asynchronous active-low reset; clears the output register.
REQ-005 a  input  8  addend A, unsigned.
REQ-006 b  input  8  addend B, unsigned.
REQ-007 cin  input  1  carry into bit 0.
REQ-008 s  output  8  registered sum bits [7:0].
REQ-009 cout  output  1  registered carry out of bit 7.

Function
REQ-010 The block SHALL compute {cout, s} = a + b + cin as a 9-bit unsigned result, with no overflow loss.
REQ-011 Per-bit generate and propagate SHALL be defined as g[i] = a[i] & b[i] and p[i] = a[i] ^ b[i], for i = 0..7.
REQ-012 Carries SHALL be formed by carry-lookahead equations, not by a ripple chain or a behavioural "+" operator:
- two 4-bit CLA groups (bits 3:0 and 7:4);
- each group produces its internal carries directly from g, p and the group carry-in;
- each group exports a group generate G and a group propagate P.
REQ-013 A second-level lookahead unit SHALL compute the carries as:
- c4 = G0 | (P0 & cin);
- cout_comb = G1 | (P1 & G0) | (P1 & P0 & cin).
REQ-014 Sum bits SHALL be s_comb[i] = p[i] ^ c[i], with c[0] = cin.
REQ-015 s and cout SHALL be registered on the rising edge of clk, so that inputs present at edge N appear on the outputs after edge N (latency 1 cycle).
REQ-016 Throughput SHALL be one new operand set per cycle, with no enable and no handshake; inputs are sampled on every edge.
REQ-017 The combinational path from a/b/cin to the register SHALL contain no state, and changes to the inputs between edges SHALL NOT affect the outputs.
REQ-018 Boundary cases:
- all-ones propagate (a ^ b = 8'hFF) SHALL forward cin to cout in the same computation;
- 8'hFF + 8'hFF + 1 SHALL yield s = 8'hFF, cout = 1.

Reset
REQ-019 While rst_n = 0, s SHALL be 8'h00 and cout SHALL be 0, independent of clk.
REQ-020 Assertion of rst_n SHALL clear the outputs immediately (asynchronously), including mid-stream; the in-flight result is discarded.
REQ-021 After rst_n deasserts, the first rising clk edge SHALL load the result of the inputs present at that edge.

Verification
REQ-022 Reset then a=00, b=00, cin=0, one edge -> s=00, cout=0.
REQ-023 Small-operand and single-carry-chain sums, each checked one edge later:
- a=05, b=03, cin=0 -> s=08, cout=0;
- a=0F, b=01, cin=0 -> s=10, cout=0 (carry crosses the group boundary).
REQ-024 Full-propagate cases, checked one edge later:
- a=A5, b=5A, cin=1 -> s=00, cout=1;
- a=AA, b=55, cin=0 -> s=FF, cout=0.
REQ-025 a=FF, b=FF, cin=1 -> s=FF, cout=1 one edge later.
REQ-026 Back-to-back vectors on consecutive edges SHALL each appear exactly one cycle later; asserting rst_n low between edges SHALL force s=00, cout=0 without waiting for a clock edge.
REQ-027 An exhaustive or random sweep of a, b, cin SHALL match the reference model {cout, s} = a + b + cin delayed by one cycle.
